batch_sequencer: RTL

BATCH_SEQUENCER -- requirements
Module: batch_sequencer

---
 rtl/ccu_pkg.sv | 13 +
 rtl/packet_timer.sv | 33 +++
 rtl/batch_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
// ccu_pkg: shared FSM states, clock/baud defaults and packet timing helper
package ccu_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} seq_state_t;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 4_000_000;

    function automatic int packet_cycles(input int clk_freq, input int baud_rate);
        return (clk_freq / baud_rate) * 10;
    endfunction

endpackage

// File: rtl/packet_timer.sv
// packet_timer: one-shot counter that flags the last cycle of a packet gap
module packet_timer #(
    parameter int CYCLES = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic expired
);

    localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;
    logic         run;

    // restart from zero on start, then count up to LAST and stop without wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            run <= cnt != LAST;
            cnt <= cnt == LAST ? cnt : cnt + 1'b1;
        end
    end

    assign expired = run && cnt == LAST;

endmodule

// File: rtl/batch_sequencer.sv
// batch_sequencer: walks the byte mux through a batch, pacing each byte by one UART packet time
module batch_sequencer
    import ccu_pkg::*;
#(
    parameter int BATCH_SIZE = 10,
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       batch_req,
    input  logic       byte_ready,
    output logic [3:0] selection,
    output logic       byte_valid,
    output logic       busy,
    output logic       batch_done,
    output logic [7:0] overrun_cnt
);

    localparam int         PACKET_CYCLES = packet_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] LAST_SEL      = 4'(BATCH_SIZE - 1);

    seq_state_t state, state_nxt;
    logic       pending, expired, start, take;

    assign take  = state == IDLE && (batch_req || pending);
    assign start = state == SEND && byte_ready;

    packet_timer #(.CYCLES(PACKET_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .expired(expired)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: handshake in SEND, packet gap in GAP, one-cycle DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = take ? SEND : IDLE;
            SEND:    state_nxt = byte_ready ? GAP : SEND;
            GAP:     state_nxt = !expired ? GAP : (selection == LAST_SEL ? DONE : SEND);
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded straight from state so the handshake has no added latency
    always_comb begin
        byte_valid = state == SEND;
        busy       = state != IDLE;
        batch_done = state == DONE;
    end

    // byte index, one-deep request queue and saturating count of dropped requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selection   <= '0;
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (take)
                selection <= '0;
            else if (state == GAP && expired && selection != LAST_SEL)
                selection <= selection + 1'b1;
            if (state == IDLE)
                pending <= pending && batch_req;
            else if (batch_req)
                pending <= 1'b1;
            if (state != IDLE && batch_req && pending && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule
